// File: rtl/truth_table_sweeper_if.sv
// Bundle between the sweeper and the combinational function it exercises.
// Carries the sweep request, the stimulus/response pair and the capture results.
interface truth_table_sweeper_if #(
  parameter int N_IN = 3
);
  localparam int T = 2 ** N_IN;

  // Handshake: start is a level or one-cycle request, sampled only while the
  // sweeper is idle or done (busy=0); while busy=1 it is ignored, so no ready
  // signal is needed. vec is valid whenever busy=1, and s must be valid by the
  // SAMPLE cycle of each vector. done is held until the next start or reset.
  logic            start;
  logic [N_IN-1:0] vec;
  logic            s;
  logic            busy;
  logic            done;
  logic [T-1:0]    table_out;
  logic [N_IN:0]   mismatch_cnt;
  logic            pass;
  logic [2:0]      state_dbg;

  modport master (
    output start, s,
    input  vec, busy, done, table_out, mismatch_cnt, pass, state_dbg
  );

  modport slave (
    input  start, s,
    output vec, busy, done, table_out, mismatch_cnt, pass, state_dbg
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Drives every input vector of a combinational function in ascending order,
// waits a settle time, captures s into a truth table and counts mismatches.
module truth_table_sweeper #(
  parameter int                    N_IN          = 3,
  parameter int                    SETTLE_CYCLES = 2,
  parameter logic [(2**N_IN)-1:0]  EXPECTED      = 8'h22
) (
  input  logic                  clk,
  input  logic                  rst_n,
  truth_table_sweeper_if.slave  bus
);
  localparam int              T        = 2 ** N_IN;
  localparam logic [N_IN:0]   LAST     = (N_IN+1)'(T - 1);
  localparam logic [N_IN:0]   ONE      = (N_IN+1)'(1);
  localparam logic [3:0]      SETTLE_L = 4'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRIVE  = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t          state;
  logic [N_IN:0]   idx;
  logic [N_IN:0]   idx_inc;
  logic [3:0]      settle_cnt;
  logic [N_IN-1:0] vec_q;
  logic [T-1:0]    table_q;
  logic [N_IN:0]   mism_q;

  // idx carries one spare bit so the terminal compare never sees a wrap.
  assign idx_inc = idx + ONE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      settle_cnt <= '0;
      vec_q      <= '0;
      table_q    <= '0;
      mism_q     <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            table_q <= '0;
            mism_q  <= '0;
            idx     <= '0;
            vec_q   <= '0;
            state   <= S_DRIVE;
          end
        end
        S_DRIVE: begin
          settle_cnt <= SETTLE_L;
          state      <= (SETTLE_CYCLES > 0) ? S_SETTLE : S_SAMPLE;
        end
        S_SETTLE: begin
          settle_cnt <= settle_cnt - 4'd1;
          if (settle_cnt == 4'd1) state <= S_SAMPLE;
        end
        S_SAMPLE: begin
          table_q[idx[N_IN-1:0]] <= bus.s;
          if (bus.s != EXPECTED[idx[N_IN-1:0]]) mism_q <= mism_q + ONE;
          if (idx == LAST) begin
            vec_q <= '0;
            state <= S_DONE;
          end else begin
            idx   <= idx_inc;
            vec_q <= idx_inc[N_IN-1:0];
            state <= S_DRIVE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.vec          = vec_q;
  assign bus.table_out    = table_q;
  assign bus.mismatch_cnt = mism_q;
  assign bus.busy         = (state == S_DRIVE) || (state == S_SETTLE) || (state == S_SAMPLE);
  assign bus.done         = (state == S_DONE);
  assign bus.pass         = (state == S_DONE) && (mism_q == '0);
  assign bus.state_dbg    = state;
endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: three instances (settle 2, 0, 15) driven by
// selectable stimulus functions, checked against a table-level reference model.
module tb_truth_table_sweeper;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start_r [3];
  int         mode_r  [3];
  logic [7:0] rand_tab = 8'h00;
  int         n_cmp = 0;
  int         n_mis = 0;

  typedef struct {
    int         sel;
    int         mode;
    int         ign_a;
    int         ign_b;
    logic [7:0] tab;
    int         mism;
    bit         pass;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  truth_table_sweeper_if #(.N_IN(3)) if0 ();
  truth_table_sweeper_if #(.N_IN(3)) if1 ();
  truth_table_sweeper_if #(.N_IN(3)) if2 ();

  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(2),  .EXPECTED(8'h22)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(0),  .EXPECTED(8'h22)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  truth_table_sweeper #(.N_IN(3), .SETTLE_CYCLES(15), .EXPECTED(8'h22)) dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  // Functions under test: 0 = ~y&z, 1 = ~x|~y, 2 = constant 1, 3 = arbitrary table.
  function automatic logic ref_s(input int mode, input logic [2:0] v, input logic [7:0] rt);
    case (mode)
      0:       return ~v[1] & v[0];
      1:       return ~v[2] | ~v[1];
      2:       return 1'b1;
      default: return rt[v];
    endcase
  endfunction

  assign if0.start = start_r[0];
  assign if1.start = start_r[1];
  assign if2.start = start_r[2];
  assign if0.s = ref_s(mode_r[0], if0.vec, rand_tab);
  assign if1.s = ref_s(mode_r[1], if1.vec, rand_tab);
  assign if2.s = ref_s(mode_r[2], if2.vec, rand_tab);

  function automatic int settle_of(input int sel);
    return (sel == 0) ? 2 : (sel == 1) ? 0 : 15;
  endfunction

  // field: 0 vec, 1 busy, 2 done, 3 table_out, 4 mismatch_cnt, 5 pass
  function automatic logic [31:0] get(input int sel, input int field);
    logic [31:0] r0, r1, r2;
    case (field)
      0:       begin r0 = 32'(if0.vec);          r1 = 32'(if1.vec);          r2 = 32'(if2.vec);          end
      1:       begin r0 = 32'(if0.busy);         r1 = 32'(if1.busy);         r2 = 32'(if2.busy);         end
      2:       begin r0 = 32'(if0.done);         r1 = 32'(if1.done);         r2 = 32'(if2.done);         end
      3:       begin r0 = 32'(if0.table_out);    r1 = 32'(if1.table_out);    r2 = 32'(if2.table_out);    end
      4:       begin r0 = 32'(if0.mismatch_cnt); r1 = 32'(if1.mismatch_cnt); r2 = 32'(if2.mismatch_cnt); end
      default: begin r0 = 32'(if0.pass);         r1 = 32'(if1.pass);         r2 = 32'(if2.pass);         end
    endcase
    return (sel == 0) ? r0 : (sel == 1) ? r1 : r2;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full sweep from IDLE or DONE; optional ignored start pulses after edges ign_a/ign_b.
  task automatic sweep(input int sel, input int mode, input int ign_a, input int ign_b,
                       input logic [7:0] exp_tab, input int exp_mism, input bit exp_pass);
    int settle;
    int lat;
    int bad;
    int first_bad;
    settle    = settle_of(sel);
    lat       = 8 * (settle + 2);
    bad       = 0;
    first_bad = -1;
    mode_r[sel] = mode;
    @(negedge clk); start_r[sel] = 1'b1;
    @(negedge clk); start_r[sel] = 1'b0;
    check("start_clear_table", get(sel, 3), 32'd0);
    check("start_clear_cnt",   get(sel, 4), 32'd0);
    check("start_done_low",    get(sel, 2), 32'd0);
    for (int e = 0; e < lat; e++) begin
      if (get(sel, 0) != 32'(e / (settle + 2)) || get(sel, 1) != 32'd1 || get(sel, 2) != 32'd0) begin
        bad++;
        if (first_bad < 0) first_bad = e;
      end
      start_r[sel] = (e == ign_a) || (e == ign_b);
      @(negedge clk);
    end
    start_r[sel] = 1'b0;
    if (bad != 0) $display("note: first sequence deviation after edge %0d (sel %0d)", first_bad, sel);
    check("vec_busy_sequence", 32'(bad), 32'd0);
    check("done_at_latency", get(sel, 2), 32'd1);
    check("busy_low_done",   get(sel, 1), 32'd0);
    check("vec_zero_done",   get(sel, 0), 32'd0);
    check("table_out",       get(sel, 3), 32'(exp_tab));
    check("mismatch_cnt",    get(sel, 4), 32'(exp_mism));
    check("pass",            get(sel, 5), 32'(exp_pass));
    @(negedge clk);
    check("done_hold",  get(sel, 2), 32'd1);
    check("table_hold", get(sel, 3), 32'(exp_tab));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [7:0] m_tab;
    int         m_mism;
    int         sel;
    int         lat;
    for (int i = 0; i < 3; i++) begin start_r[i] = 1'b0; mode_r[i] = 0; end
    vecs[0] = '{sel: 0, mode: 0, ign_a: -1, ign_b: -1, tab: 8'h22, mism: 0, pass: 1'b1};
    vecs[1] = '{sel: 0, mode: 1, ign_a: -1, ign_b: -1, tab: 8'h3F, mism: 4, pass: 1'b0};
    vecs[2] = '{sel: 0, mode: 0, ign_a: 5,  ign_b: 20, tab: 8'h22, mism: 0, pass: 1'b1};
    vecs[3] = '{sel: 0, mode: 2, ign_a: -1, ign_b: -1, tab: 8'hFF, mism: 6, pass: 1'b0};
    vecs[4] = '{sel: 1, mode: 0, ign_a: -1, ign_b: -1, tab: 8'h22, mism: 0, pass: 1'b1};
    vecs[5] = '{sel: 2, mode: 0, ign_a: 3,  ign_b: 100, tab: 8'h22, mism: 0, pass: 1'b1};

    // Clock/reset
    #2 rst_n = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      check("reset_vec",   get(i, 0), 32'd0);
      check("reset_busy",  get(i, 1), 32'd0);
      check("reset_done",  get(i, 2), 32'd0);
      check("reset_table", get(i, 3), 32'd0);
      check("reset_cnt",   get(i, 4), 32'd0);
      check("reset_pass",  get(i, 5), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1;

    // Table-driven sweeps; vecs[3] restarts straight from DONE after a pass.
    for (int k = 0; k < 6; k++)
      sweep(vecs[k].sel, vecs[k].mode, vecs[k].ign_a, vecs[k].ign_b,
            vecs[k].tab, vecs[k].mism, vecs[k].pass);

    // Asynchronous reset during vector 3 SETTLE discards the partial sweep.
    mode_r[0] = 0;
    @(negedge clk); start_r[0] = 1'b1;
    @(negedge clk); start_r[0] = 1'b0;
    repeat (13) @(negedge clk);
    check("mid_vec_before_reset", get(0, 0), 32'd3);
    check("mid_busy_before_reset", get(0, 1), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_vec",   get(0, 0), 32'd0);
    check("async_busy",  get(0, 1), 32'd0);
    check("async_done",  get(0, 2), 32'd0);
    check("async_table", get(0, 3), 32'd0);
    check("async_cnt",   get(0, 4), 32'd0);
    check("async_pass",  get(0, 5), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", get(0, 1), 32'd0);
    sweep(0, 0, -1, -1, 8'h22, 0, 1'b1);

    // Randomized truth tables against the table-level reference model.
    for (int r = 0; r < 8; r++) begin
      rand_tab = (r == 0) ? 8'h22 : 8'($urandom_range(0, 255));
      sel = $urandom_range(0, 2);
      lat = 8 * (settle_of(sel) + 2);
      for (int i = 0; i < 8; i++) m_tab[i] = ref_s(3, 3'(i), rand_tab);
      m_mism = $countones(m_tab ^ 8'h22);
      sweep(sel, 3, $urandom_range(0, lat - 1), $urandom_range(0, lat - 1),
            m_tab, m_mism, m_mism == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
